// File: rtl/fetch_ctrl.sv
// Fetch-stage controller: owns the program counter and steers the F/D
// register (pass / pass-unless-redirect / bubble / halt). It decodes the
// fetched word into register indices, an immediate and a short jump address.
module fetch_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic [9:0]  instr_in,
  input  logic        jmp_control,
  input  logic        comp_contr,
  input  logic [9:0]  jmp_target,
  input  logic [1:0]  ldst,
  output logic [9:0]  pc,
  output logic [1:0]  fetch_op,
  output logic [9:0]  instr0,
  output logic [9:0]  instr_addr0,
  output logic [9:0]  pc_val0,
  output logic [2:0]  read_reg10,
  output logic [2:0]  read_reg20,
  output logic [9:0]  imm_val0,
  output logic [9:0]  jmp_addr0,
  output logic [15:0] fetch_count
);

  typedef enum logic [2:0] {
    BOOT,
    RUN,
    REDIR,
    STALL,
    HALT
  } state_t;

  localparam logic [1:0] OP_PASS   = 2'b00;
  localparam logic [1:0] OP_PASSNR = 2'b01;
  localparam logic [1:0] OP_BUBBLE = 2'b10;
  localparam logic [1:0] OP_HALT   = 2'b11;

  state_t      state;
  logic        redirect;
  logic        load_use;
  logic        halt_op;
  logic [9:0]  pc_inc;

  assign redirect = jmp_control | comp_contr;
  assign load_use = (ldst == 2'b10);
  assign halt_op  = (instr_in[9:6] == 4'b1111);
  assign pc_inc   = pc + 10'd1;

  // Decode taps on the fetched word, passed straight through to decode.
  assign instr0      = instr_in;
  assign instr_addr0 = pc;
  assign pc_val0     = pc_inc;
  assign read_reg10  = instr_in[5:3];
  assign read_reg20  = instr_in[2:0];
  assign imm_val0    = {{4{instr_in[5]}}, instr_in[5:0]};
  assign jmp_addr0   = {4'b0000, instr_in[5:0]};

  // State, program counter and retired-fetch counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= BOOT;
      pc          <= '0;
      fetch_count <= '0;
    end else begin
      case (state)
        BOOT: state <= RUN;
        RUN: begin
          if (redirect) begin
            pc    <= jmp_target;
            state <= REDIR;
          end else if (load_use) begin
            state <= STALL;
          end else if (halt_op) begin
            state <= HALT;
          end else begin
            pc          <= pc_inc;
            fetch_count <= fetch_count + 16'd1;
          end
        end
        // Redirect inputs are ignored here: the target word is being fetched.
        REDIR: begin
          if (load_use) begin
            state <= STALL;
          end else begin
            pc          <= pc_inc;
            fetch_count <= fetch_count + 16'd1;
            state       <= RUN;
          end
        end
        // Leaving a stall takes one extra cycle with pc held.
        STALL: begin
          if (redirect) begin
            pc    <= jmp_target;
            state <= REDIR;
          end else if (!load_use) begin
            state <= RUN;
          end
        end
        HALT:    state <= HALT;
        default: state <= BOOT;
      endcase
    end
  end

  // F/D register control, a function of current state and this cycle's inputs.
  always_comb begin
    fetch_op = OP_BUBBLE;
    case (state)
      BOOT:  fetch_op = OP_BUBBLE;
      RUN: begin
        if (redirect)      fetch_op = OP_PASSNR;
        else if (load_use) fetch_op = OP_BUBBLE;
        else if (halt_op)  fetch_op = OP_HALT;
        else               fetch_op = OP_PASSNR;
      end
      REDIR: fetch_op = load_use ? OP_BUBBLE : OP_PASS;
      STALL: fetch_op = OP_BUBBLE;
      HALT:  fetch_op = OP_HALT;
      default: fetch_op = OP_BUBBLE;
    endcase
  end

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed bench for fetch_ctrl with hand-computed expectations.
module tb_fetch_ctrl;

  logic        clk;
  logic        rst;
  logic [9:0]  instr_in;
  logic        jmp_control;
  logic        comp_contr;
  logic [9:0]  jmp_target;
  logic [1:0]  ldst;
  logic [9:0]  pc;
  logic [1:0]  fetch_op;
  logic [9:0]  instr0;
  logic [9:0]  instr_addr0;
  logic [9:0]  pc_val0;
  logic [2:0]  read_reg10;
  logic [2:0]  read_reg20;
  logic [9:0]  imm_val0;
  logic [9:0]  jmp_addr0;
  logic [15:0] fetch_count;

  int unsigned n_cmp;
  int unsigned n_err;

  fetch_ctrl dut (
    .clk         (clk),
    .rst         (rst),
    .instr_in    (instr_in),
    .jmp_control (jmp_control),
    .comp_contr  (comp_contr),
    .jmp_target  (jmp_target),
    .ldst        (ldst),
    .pc          (pc),
    .fetch_op    (fetch_op),
    .instr0      (instr0),
    .instr_addr0 (instr_addr0),
    .pc_val0     (pc_val0),
    .read_reg10  (read_reg10),
    .read_reg20  (read_reg20),
    .imm_val0    (imm_val0),
    .jmp_addr0   (jmp_addr0),
    .fetch_count (fetch_count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance one clock and settle just past the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Inputs are applied, then outputs sampled mid-cycle.
  task automatic expect_cycle(input string tag, input logic [9:0] e_pc,
                              input logic [1:0] e_op, input logic [15:0] e_cnt);
    #2;
    check({tag, ".pc"}, {6'd0, pc}, {6'd0, e_pc});
    check({tag, ".op"}, {14'd0, fetch_op}, {14'd0, e_op});
    check({tag, ".cnt"}, fetch_count, e_cnt);
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst = 1'b1;
    instr_in = 10'h001;
    jmp_control = 1'b0;
    comp_contr = 1'b0;
    jmp_target = 10'h000;
    ldst = 2'b00;

    tick();
    expect_cycle("reset", 10'h000, 2'b10, 16'd0);

    // Boot then straight-line fetch.
    tick();
    rst = 1'b0;
    expect_cycle("boot", 10'h000, 2'b10, 16'd0);
    tick(); expect_cycle("run0", 10'h000, 2'b01, 16'd0);
    tick(); expect_cycle("run1", 10'h001, 2'b01, 16'd1);
    tick(); expect_cycle("run2", 10'h002, 2'b01, 16'd2);
    tick(); expect_cycle("run3", 10'h003, 2'b01, 16'd3);

    // Decode taps (halt opcode not present).
    instr_in = 10'h02E;
    #1;
    check("instr0", {6'd0, instr0}, 16'h002E);
    check("iaddr0", {6'd0, instr_addr0}, 16'h0003);
    check("pcval0", {6'd0, pc_val0}, 16'h0004);
    check("rreg1", {13'd0, read_reg10}, 16'd5);
    check("rreg2", {13'd0, read_reg20}, 16'd6);
    check("imm", {6'd0, imm_val0}, 16'h03EE);
    check("jaddr", {6'd0, jmp_addr0}, 16'h002E);
    instr_in = 10'h019;
    #1;
    check("imm_pos", {6'd0, imm_val0}, 16'h0019);
    instr_in = 10'h001;

    tick(); expect_cycle("run4", 10'h004, 2'b01, 16'd4);
    tick();
    // Conditional branch at pc=5.
    comp_contr = 1'b1;
    jmp_target = 10'h040;
    expect_cycle("br", 10'h005, 2'b01, 16'd5);
    tick();
    comp_contr = 1'b0;
    expect_cycle("redir", 10'h040, 2'b00, 16'd5);
    tick();
    // Redirect toward 6 so that RUN reaches pc=7.
    jmp_control = 1'b1;
    jmp_target = 10'h006;
    expect_cycle("run41", 10'h041, 2'b01, 16'd6);
    tick();
    jmp_control = 1'b0;
    expect_cycle("redir6", 10'h006, 2'b00, 16'd6);
    tick();

    // Load-use stall held three cycles at pc=7.
    ldst = 2'b10;
    expect_cycle("st0", 10'h007, 2'b10, 16'd7);
    tick(); expect_cycle("st1", 10'h007, 2'b10, 16'd7);
    tick(); expect_cycle("st2", 10'h007, 2'b10, 16'd7);
    tick();
    ldst = 2'b00;
    expect_cycle("strel", 10'h007, 2'b10, 16'd7);
    tick(); expect_cycle("strun", 10'h007, 2'b01, 16'd7);
    tick(); expect_cycle("pc8", 10'h008, 2'b01, 16'd8);
    tick();

    // Halt opcode at pc=9; later inputs ignored.
    instr_in = 10'h3C0;
    expect_cycle("hop", 10'h009, 2'b11, 16'd9);
    tick();
    jmp_control = 1'b1;
    jmp_target = 10'h100;
    ldst = 2'b10;
    expect_cycle("halt0", 10'h009, 2'b11, 16'd9);
    tick(); expect_cycle("halt1", 10'h009, 2'b11, 16'd9);
    tick();
    jmp_control = 1'b0;
    ldst = 2'b00;
    instr_in = 10'h001;
    expect_cycle("halt2", 10'h009, 2'b11, 16'd9);

    // Asynchronous reset out of HALT, mid-cycle.
    rst = 1'b1;
    expect_cycle("rsthalt", 10'h000, 2'b10, 16'd0);
    tick();
    rst = 1'b0;
    expect_cycle("boot2", 10'h000, 2'b10, 16'd0);
    tick();

    // Wrap: redirect to 3FE then run through 3FF.
    jmp_control = 1'b1;
    jmp_target = 10'h3FE;
    expect_cycle("wrapj", 10'h000, 2'b01, 16'd0);
    tick();
    jmp_control = 1'b0;
    expect_cycle("w3fe", 10'h3FE, 2'b00, 16'd0);
    tick();
    expect_cycle("w3ff", 10'h3FF, 2'b01, 16'd1);
    check("pcval_wrap", {6'd0, pc_val0}, 16'h0000);
    tick(); expect_cycle("w000", 10'h000, 2'b01, 16'd2);

    // Redirect beats stall and halt; redirect ignored while in REDIR.
    jmp_control = 1'b1;
    ldst = 2'b10;
    instr_in = 10'h3C0;
    jmp_target = 10'h123;
    expect_cycle("prio", 10'h000, 2'b01, 16'd2);
    tick();
    ldst = 2'b00;
    instr_in = 10'h001;
    jmp_target = 10'h200;
    expect_cycle("prio_rd", 10'h123, 2'b00, 16'd2);
    tick();
    jmp_control = 1'b0;
    expect_cycle("prio_run", 10'h124, 2'b01, 16'd3);

    // Redirect equal to current pc.
    jmp_control = 1'b1;
    jmp_target = 10'h124;
    tick();
    jmp_control = 1'b0;
    expect_cycle("selfj", 10'h124, 2'b00, 16'd3);
    tick(); expect_cycle("selfr", 10'h125, 2'b01, 16'd4);

    // Redirect while stalled, then reset in the middle of a stall.
    ldst = 2'b10;
    tick();
    jmp_control = 1'b1;
    jmp_target = 10'h050;
    expect_cycle("stj", 10'h125, 2'b10, 16'd4);
    tick();
    jmp_control = 1'b0;
    expect_cycle("stjrd", 10'h050, 2'b10, 16'd4);
    tick();
    expect_cycle("stagain", 10'h050, 2'b10, 16'd4);
    rst = 1'b1;
    expect_cycle("rststall", 10'h000, 2'b10, 16'd0);
    tick();
    rst = 1'b0;
    ldst = 2'b00;
    expect_cycle("boot3", 10'h000, 2'b10, 16'd0);
    tick(); expect_cycle("run_post", 10'h000, 2'b01, 16'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/fetch_ctrl.md
FETCH_CTRL -- requirements
Module: fetch_ctrl

Interface
REQ-001 One clock; reset is asynchronous and active-high; ports clk and rst.
REQ-002 clk  in  1  rising-edge clock for all state.
REQ-003 rst  in  1  async active-high reset.
REQ-004 instr_in  in  10  instruction-memory read data for address pc, same cycle.
REQ-005 jmp_control  in  1  unconditional jump resolved downstream this cycle.
REQ-006 comp_contr  in  1  conditional branch taken this cycle.
REQ-007 jmp_target  in  10  redirect address, valid when jmp_control|comp_contr.
REQ-008 ldst  in  2  load/store hazard code; 2'b10 = load-use stall.
REQ-009 pc  out  10  registered program counter, drives instruction memory.
REQ-010 fetch_op  out  2  to F/D register: 00 pass, 01 pass-unless-redirect, 10 bubble, 11 halt.
REQ-011 instr0  out  10  = instr_in.
REQ-012 instr_addr0  out  10  = pc.
REQ-013 pc_val0  out  10  = pc+1, mod 1024.
REQ-014 read_reg10 / read_reg20  out  3 each  = instr_in[5:3] / instr_in[2:0].
REQ-015 imm_val0  out  10  = instr_in[5:0] sign-extended from bit 5.
REQ-016 jmp_addr0  out  10  = {4'b0000, instr_in[5:0]}.
REQ-017 fetch_count  out  16  registered count of instructions passed to decode.

Function
REQ-018 States BOOT, RUN, REDIR, STALL, HALT; state, pc, fetch_count are the only flops; all other outputs combinational from state and inputs.
REQ-019 BOOT: fetch_op=10, pc holds; next state RUN unconditionally.
REQ-020 Priority in RUN, highest first: redirect (jmp_control|comp_contr), stall (ldst==10), halt opcode (instr_in[9:6]==1111), normal.
REQ-021 RUN redirect: fetch_op=01, pc<=jmp_target, next REDIR; fetch_count unchanged.
REQ-022 RUN stall: fetch_op=10, pc holds, next STALL.
REQ-023 RUN halt opcode: fetch_op=11, pc holds, next HALT.
REQ-024 RUN normal: fetch_op=01, pc<=pc+1, fetch_count+=1, stay RUN.
REQ-025 REDIR: fetch_op=00, pc<=pc+1, fetch_count+=1, next RUN; jmp_control/comp_contr ignored for this one cycle; ldst==10 in REDIR → fetch_op=10, pc holds, next STALL.
REQ-026 STALL: fetch_op=10, pc holds while ldst==10; redirect in STALL wins (pc<=jmp_target, next REDIR); ldst!=10 and no redirect → next RUN, pc holds this cycle.
REQ-027 HALT: fetch_op=11, pc and fetch_count hold; all inputs ignored; exit only via rst.
REQ-028 pc increment wraps 10'h3FF → 10'h000 with no flag; pc_val0 wraps identically.
REQ-029 fetch_count wraps 16'hFFFF → 16'h0000.
REQ-030 jmp_target == pc is legal; behaves as any redirect.

Reset
REQ-031 rst asserted: immediately state=BOOT, pc=0, fetch_count=0; fetch_op=10 while rst high.
REQ-032 rst mid-STALL, REDIR or HALT aborts with no residual state; first cycle after release is BOOT.

Verification
REQ-033 Release reset, instr_in=10'h001 constant → fetch_op 10 one cycle, then 01; pc 0,1,2,3; fetch_count 3 after third RUN cycle.
REQ-034 At pc=5 pulse comp_contr, jmp_target=10'h040 → same cycle fetch_op=01; next pc=0x040, fetch_op=00; following pc=0x041, state RUN.
REQ-035 At pc=7 hold ldst=10 three cycles → fetch_op=10 ×3, pc stays 7, fetch_count frozen; release → RUN, pc 8 one cycle later.
REQ-036 instr_in=10'b1111000000 at pc=9 → fetch_op=11 forever, pc=9 despite jmp_control pulses; rst → pc=0, BOOT.
REQ-037 Force pc to 10'h3FF via redirect, run normally → pc_val0=0 at pc=3FF, next pc=0.
REQ-038 Simultaneous jmp_control=1, ldst=10, halt opcode in RUN → redirect taken, pc=jmp_target, state REDIR.
